// File: rtl/tournament_chooser.sv
// Tournament chooser: a table of 2-bit saturating counters that picks
// between a global and a local branch predictor. The table is filled with
// INIT_CTR by a small init FSM after reset; predictions come out one cycle
// after the request, and resolved branches train the counters and the GHR.
module tournament_chooser #(
  parameter int         IDX_W    = 6,
  parameter int         PC_W     = 32,
  parameter bit         USE_GHR  = 1'b1,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic             clk_i,
  input  logic             reset_i,
  output logic             ready_o,
  input  logic             pred_v_i,
  input  logic [PC_W-1:0]  pred_pc_i,
  input  logic             global_pred_i,
  input  logic             local_pred_i,
  output logic             pred_v_o,
  output logic             pred_taken_o,
  output logic             pred_sel_global_o,
  output logic [1:0]       pred_ctr_o,
  input  logic             upd_v_i,
  input  logic [PC_W-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic             upd_global_correct_i,
  input  logic             upd_local_correct_i,
  output logic [IDX_W-1:0] ghr_o
);

  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_init_cnt;
  logic [IDX_W-1:0] r_ghr;
  logic             r_pred_v;
  logic             r_pred_taken;
  logic             r_pred_sel_global;
  logic [1:0]       r_pred_ctr;
  logic [1:0]       r_table [ENTRIES];

  logic             w_ready;
  logic             w_pred_accept;
  logic             w_upd_accept;
  logic [IDX_W-1:0] w_ghr_mix;
  logic [IDX_W-1:0] w_pred_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic [1:0]       w_pred_ctr;
  logic [1:0]       w_upd_ctr;
  logic [1:0]       w_upd_ctr_next;
  logic             w_sel_global;
  logic             w_taken;
  logic             w_unused_pc_bits;

  // Only pc[IDX_W+1:2] contributes to the index; the rest is deliberately ignored.
  assign w_unused_pc_bits = ^{pred_pc_i[PC_W-1:IDX_W+2], pred_pc_i[1:0],
                              upd_pc_i[PC_W-1:IDX_W+2], upd_pc_i[1:0]};

  assign w_ready       = (r_state == S_READY);
  assign w_pred_accept = pred_v_i && w_ready;
  assign w_upd_accept  = upd_v_i && w_ready;

  // Both ports index with the GHR as it stands this cycle (pre-shift).
  assign w_ghr_mix  = USE_GHR ? r_ghr : '0;
  assign w_pred_idx = pred_pc_i[IDX_W+1:2] ^ w_ghr_mix;
  assign w_upd_idx  = upd_pc_i[IDX_W+1:2] ^ w_ghr_mix;

  // Asynchronous reads: the prediction sees the pre-update counter on a
  // same-index collision because the write lands only at the clock edge.
  assign w_pred_ctr = r_table[w_pred_idx];
  assign w_upd_ctr  = r_table[w_upd_idx];

  assign w_sel_global = (w_pred_ctr >= 2'b10);
  assign w_taken      = (global_pred_i == local_pred_i) ? global_pred_i :
                        (w_sel_global ? global_pred_i : local_pred_i);

  // Saturating train step: move toward whichever predictor alone was right.
  always_comb begin
    w_upd_ctr_next = w_upd_ctr;
    if (upd_global_correct_i && !upd_local_correct_i) begin
      if (w_upd_ctr != 2'b11) w_upd_ctr_next = w_upd_ctr + 2'b01;
    end else if (upd_local_correct_i && !upd_global_correct_i) begin
      if (w_upd_ctr != 2'b00) w_upd_ctr_next = w_upd_ctr - 2'b01;
    end
  end

  // Counter table: init sweep writes one entry per cycle, then training writes.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (r_state == S_INIT) begin
        r_table[r_init_cnt] <= INIT_CTR;
      end else if (w_upd_accept) begin
        r_table[w_upd_idx] <= w_upd_ctr_next;
      end
    end
  end

  // Control FSM, history register and registered prediction outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state           <= S_INIT;
      r_init_cnt        <= '0;
      r_ghr             <= '0;
      r_pred_v          <= 1'b0;
      r_pred_taken      <= 1'b0;
      r_pred_sel_global <= 1'b0;
      r_pred_ctr        <= 2'b00;
    end else begin
      case (r_state)
        S_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == '1) r_state <= S_READY;
        end
        default: r_state <= S_READY;
      endcase
      if (w_upd_accept) r_ghr <= {r_ghr[IDX_W-2:0], upd_taken_i};
      r_pred_v <= w_pred_accept;
      if (w_pred_accept) begin
        r_pred_taken      <= w_taken;
        r_pred_sel_global <= w_sel_global;
        r_pred_ctr        <= w_pred_ctr;
      end
    end
  end

  assign ready_o           = w_ready;
  assign pred_v_o          = r_pred_v;
  assign pred_taken_o      = r_pred_taken;
  assign pred_sel_global_o = r_pred_sel_global;
  assign pred_ctr_o        = r_pred_ctr;
  assign ghr_o             = r_ghr;

endmodule

// File: tb/tb_tournament_chooser.sv
// Testbench for tournament_chooser (IDX_W=6, PC_W=32, USE_GHR=1, INIT_CTR=01).
// Predictions are checked through a scoreboard fed by a reference table model;
// directed scenarios add literal checks on top.
module tb_tournament_chooser;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ready_o;
  logic        pred_v_i;
  logic [31:0] pred_pc_i;
  logic        global_pred_i;
  logic        local_pred_i;
  logic        pred_v_o;
  logic        pred_taken_o;
  logic        pred_sel_global_o;
  logic [1:0]  pred_ctr_o;
  logic        upd_v_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic        upd_global_correct_i;
  logic        upd_local_correct_i;
  logic [5:0]  ghr_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [1:0] m_table [64];
  logic [5:0] m_ghr;
  bit         m_ready;
  logic [3:0] sb [$];   // {taken, sel_global, ctr}

  tournament_chooser #(
    .IDX_W(6), .PC_W(32), .USE_GHR(1'b1), .INIT_CTR(2'b01)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .ready_o(ready_o),
    .pred_v_i(pred_v_i), .pred_pc_i(pred_pc_i),
    .global_pred_i(global_pred_i), .local_pred_i(local_pred_i),
    .pred_v_o(pred_v_o), .pred_taken_o(pred_taken_o),
    .pred_sel_global_o(pred_sel_global_o), .pred_ctr_o(pred_ctr_o),
    .upd_v_i(upd_v_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_global_correct_i(upd_global_correct_i),
    .upd_local_correct_i(upd_local_correct_i), .ghr_o(ghr_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard monitor: every result cycle must match the oldest expectation.
  always @(negedge clk_i) begin
    logic [3:0] exp_r;
    if (pred_v_o === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pred_unexpected: got pred_v_o=1 required no result");
      end else begin
        exp_r = sb.pop_front();
        if ({pred_taken_o, pred_sel_global_o, pred_ctr_o} !== exp_r) begin
          n_fail++;
          $display("FAIL pred_result: got taken=%b sel=%b ctr=%0d required taken=%b sel=%b ctr=%0d",
                   pred_taken_o, pred_sel_global_o, pred_ctr_o, exp_r[3], exp_r[2], exp_r[1:0]);
        end
      end
    end else if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      exp_r = sb.pop_front();
      $display("FAIL pred_missing: got pred_v_o=%b required 1 (ctr=%0d)", pred_v_o, exp_r[1:0]);
    end
  end

  task automatic model_init();
    for (int i = 0; i < 64; i++) m_table[i] = 2'b01;
    m_ghr = '0;
  endtask

  // One clock of stimulus; inputs change #1 after the edge.
  task automatic step(input logic pv, input logic [31:0] pc, input logic g, input logic l,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic gc, input logic lc);
    logic [5:0] pi;
    logic [5:0] ui;
    logic [1:0] c;
    logic       sel;
    logic       tk;
    logic [3:0] exp_r;
    bit         push;
    pred_v_i = pv; pred_pc_i = pc; global_pred_i = g; local_pred_i = l;
    upd_v_i = uv; upd_pc_i = upc; upd_taken_i = ut;
    upd_global_correct_i = gc; upd_local_correct_i = lc;
    push = 1'b0;
    exp_r = '0;
    if (pv && m_ready) begin
      pi = pc[7:2] ^ m_ghr;
      c = m_table[pi];
      sel = (c >= 2'b10);
      tk = (g == l) ? g : (sel ? g : l);
      exp_r = {tk, sel, c};
      push = 1'b1;
    end
    @(posedge clk_i);
    if (push) sb.push_back(exp_r);
    if (uv && m_ready) begin
      ui = upc[7:2] ^ m_ghr;
      if (gc && !lc && m_table[ui] != 2'b11) m_table[ui] = m_table[ui] + 2'b01;
      else if (lc && !gc && m_table[ui] != 2'b00) m_table[ui] = m_table[ui] - 2'b01;
      m_ghr = {m_ghr[4:0], ut};
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Wait for ready_o with junk requests/updates applied; they must be dropped.
  task automatic wait_ready(output int n);
    n = 0;
    pred_v_i = 1'b1; pred_pc_i = 32'h44; global_pred_i = 1'b1; local_pred_i = 1'b0;
    upd_v_i = 1'b1; upd_pc_i = 32'h44; upd_taken_i = 1'b1;
    upd_global_correct_i = 1'b1; upd_local_correct_i = 1'b0;
    while (ready_o !== 1'b1 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    pred_v_i = 1'b0; upd_v_i = 1'b0;
    n_checks++;
    if (n != 64) begin
      n_fail++;
      $display("FAIL init_latency: got %0d cycles required 64", n);
    end
    model_init();
    m_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    m_ready = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset_i = 1'b1; m_ready = 1'b0;
    pred_v_i = 0; pred_pc_i = 0; global_pred_i = 0; local_pred_i = 0;
    upd_v_i = 0; upd_pc_i = 0; upd_taken_i = 0;
    upd_global_correct_i = 0; upd_local_correct_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if ({ready_o, pred_v_o, pred_taken_o, pred_sel_global_o, pred_ctr_o, ghr_o} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b v=%b tk=%b sel=%b ctr=%0d ghr=%0d required all 0",
               ready_o, pred_v_o, pred_taken_o, pred_sel_global_o, pred_ctr_o, ghr_o);
    end
    reset_i = 1'b0;
    wait_ready(n);
    n_checks++;
    if (ghr_o !== 6'd0) begin
      n_fail++;
      $display("FAIL init_ghr_ignored: got ghr=%b required 000000", ghr_o);
    end
    // Read every entry: all must hold INIT_CTR.
    for (int i = 0; i < 64; i++) step(1, i << 2, 1, 0, 0, 0, 0, 0, 0);
    idle();
  endtask

  task automatic test_saturation();
    logic [31:0] pc = 32'h40;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1, pc, 0, 1, 0);
      step(1, pc, 1, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (pred_ctr_o !== ((k == 0) ? 2'd2 : 2'd3)) begin
        n_fail++;
        $display("FAIL sat_up_%0d: got ctr=%0d required %0d", k, pred_ctr_o, (k == 0) ? 2 : 3);
      end
    end
    n_checks++;
    if ({pred_taken_o, pred_sel_global_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL sat_select_global: got taken=%b sel=%b required 1 1", pred_taken_o, pred_sel_global_o);
    end
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, pc, 0, 0, 1);
    step(1, pc, 1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({pred_taken_o, pred_sel_global_o, pred_ctr_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL sat_down: got taken=%b sel=%b ctr=%0d required 0 0 0",
               pred_taken_o, pred_sel_global_o, pred_ctr_o);
    end
    idle();
  endtask

  task automatic test_agreement();
    // Entry 16 is at 0 (selects local), yet agreement wins.
    step(1, 32'h40, 1, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (pred_taken_o !== 1'b1) begin
      n_fail++;
      $display("FAIL agree_taken1: got %b required 1", pred_taken_o);
    end
    step(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (pred_taken_o !== 1'b0) begin
      n_fail++;
      $display("FAIL agree_taken0: got %b required 0", pred_taken_o);
    end
    for (int i = 0; i < 8; i++) step(1, $urandom, i[0], i[0], 0, 0, 0, 0, 0);
    idle();
  endtask

  task automatic test_collision();
    step(1, 32'h80, 1, 0, 1, 32'h80, 0, 1, 0);
    n_checks++;
    if (pred_ctr_o !== 2'd1) begin
      n_fail++;
      $display("FAIL collide_pre: got ctr=%0d required 1", pred_ctr_o);
    end
    step(1, 32'h80, 1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (pred_ctr_o !== 2'd2) begin
      n_fail++;
      $display("FAIL collide_post: got ctr=%0d required 2", pred_ctr_o);
    end
    idle();
    n_checks++;
    if ({pred_v_o, pred_taken_o, pred_sel_global_o, pred_ctr_o} !== 5'b01110) begin
      n_fail++;
      $display("FAIL hold_outputs: got v=%b tk=%b sel=%b ctr=%0d required 0 1 1 2",
               pred_v_o, pred_taken_o, pred_sel_global_o, pred_ctr_o);
    end
  endtask

  task automatic test_ghr();
    int n;
    pulse_reset();
    wait_ready(n);
    step(0, 0, 0, 0, 1, 32'h100, 1, 1, 1);
    step(0, 0, 0, 0, 1, 32'h100, 0, 1, 1);
    // ghr=2 here; pc idx 7 ^ 2 = entry 5, trained up to 2
    step(0, 0, 0, 0, 1, 32'h1C, 1, 1, 0);
    n_checks++;
    if (ghr_o !== 6'b000101) begin
      n_fail++;
      $display("FAIL ghr_value: got %b required 000101", ghr_o);
    end
    step(1, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({pred_sel_global_o, pred_ctr_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL ghr_index: got sel=%b ctr=%0d required sel=1 ctr=2 (entry 5)",
               pred_sel_global_o, pred_ctr_o);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 1'($urandom),
           1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle();
    n_checks++;
    if (ghr_o !== m_ghr) begin
      n_fail++;
      $display("FAIL b2b_ghr: got %b required %b", ghr_o, m_ghr);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    // Reset in READY with a request in the same cycle: result discarded.
    pred_v_i = 1'b1; pred_pc_i = 32'h40; global_pred_i = 1; local_pred_i = 0;
    upd_v_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1;
    upd_global_correct_i = 1; upd_local_correct_i = 0;
    pulse_reset();
    n_checks++;
    if ({pred_v_o, ready_o, ghr_o, pred_ctr_o} !== 10'd0) begin
      n_fail++;
      $display("FAIL midreset_state: got v=%b ready=%b ghr=%b ctr=%0d required all 0",
               pred_v_o, ready_o, ghr_o, pred_ctr_o);
    end
    // Let init run partway, then reset again: full sweep must restart.
    repeat (10) begin @(posedge clk_i); #1; end
    pulse_reset();
    wait_ready(n);
    n_checks++;
    if (ghr_o !== 6'd0) begin
      n_fail++;
      $display("FAIL midreset_ghr: got %b required 000000", ghr_o);
    end
    step(1, 32'h40, 1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (pred_ctr_o !== 2'd1) begin
      n_fail++;
      $display("FAIL midreset_reinit: got ctr=%0d required 1", pred_ctr_o);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_agreement();
    test_collision();
    test_ghr();
    test_back_to_back();
    test_reset_mid();
    repeat (2) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tournament_chooser.md
TOURNAMENT_CHOOSER -- requirements
Module: tournament_chooser

Interface
REQ-001 The block SHALL expose parameter IDX_W, default 6, log2 of chooser-table entries.
REQ-002 The block SHALL expose parameter PC_W, default 32, program-counter width (PC_W >= IDX_W+2).
REQ-003 The block SHALL expose parameter USE_GHR, default 1, index mode: 1 = pc-bits XOR global history, 0 = pc-bits only.
REQ-004 The block SHALL expose parameter INIT_CTR, default 2'b01, chooser-counter value written during initialisation.
REQ-005 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port reset_i, input, 1: synchronous, active-high reset.
REQ-007 Port ready_o, output, 1: table initialised; requests accepted.
REQ-008 Port pred_v_i, input, 1: prediction request valid.
REQ-009 Port pred_pc_i, input, PC_W: PC of the branch being predicted.
REQ-010 Port global_pred_i, input, 1: global-predictor direction for the request.
REQ-011 Port local_pred_i, input, 1: local-predictor direction for the request.
REQ-012 Port pred_v_o, output, 1: prediction result valid.
REQ-013 Port pred_taken_o, output, 1: final predicted direction.
REQ-014 Port pred_sel_global_o, output, 1: chooser selected global.
REQ-015 Port pred_ctr_o, output, 2: chooser counter value used.
REQ-016 Port upd_v_i, input, 1: branch-resolution update valid.
REQ-017 Port upd_pc_i, input, PC_W: PC of the resolved branch.
REQ-018 Port upd_taken_i, input, 1: actual branch outcome.
REQ-019 Port upd_global_correct_i, input, 1: global predictor was correct.
REQ-020 Port upd_local_correct_i, input, 1: local predictor was correct.
REQ-021 Port ghr_o, output, IDX_W: current global history register.

Function
REQ-022 Table: 2^IDX_W two-bit saturating counters; idx = pc[IDX_W+1:2] XOR ghr when USE_GHR=1, else pc[IDX_W+1:2]; same rule for prediction and update, each using the ghr value current in its cycle.
REQ-023 FSM states: INIT, READY; INIT writes INIT_CTR to entry init_cnt each cycle, init_cnt 0..2^IDX_W-1; after the last entry -> READY; ready_o = 1 only in READY.
REQ-024 Prediction latency 1 cycle: pred_v_i && ready_o in cycle N -> pred_v_o = 1 in cycle N+1 for one cycle; pred_v_i while !ready_o dropped, no pred_v_o.
REQ-025 Selection: global_pred_i == local_pred_i -> pred_taken_o = that value; else ctr >= 2'b10 -> global_pred_i, else local_pred_i; pred_sel_global_o = (ctr >= 2'b10) regardless of agreement.
REQ-026 pred_taken_o, pred_sel_global_o, pred_ctr_o hold their last values while pred_v_o = 0.
REQ-027 Update, when upd_v_i && ready_o: global correct only -> ctr+1 saturating at 3; local correct only -> ctr-1 saturating at 0; both or neither correct -> unchanged.
REQ-028 GHR: on every accepted update, ghr <= {ghr[IDX_W-2:0], upd_taken_i}; updates while !ready_o ignored entirely (table and GHR).
REQ-029 Same-cycle prediction and update to the same index: prediction reads the pre-update counter; new value visible from the next cycle.
REQ-030 Same-cycle prediction and update: prediction index uses the pre-shift ghr.
REQ-031 Back-to-back requests every cycle SHALL be supported with one result per cycle, no stalls in READY.

Reset
REQ-032 reset_i high at a clock edge: FSM -> INIT, init_cnt = 0, ghr = 0, pred_v_o = 0, pred_taken_o = 0, pred_sel_global_o = 0, pred_ctr_o = 0, ready_o = 0.
REQ-033 reset_i asserted mid-INIT or mid-operation SHALL restart full initialisation; in-flight prediction discarded (pred_v_o = 0 next cycle).

Verification
REQ-034 Reset, IDX_W=6: hold reset 1 cycle, release -> ready_o rises exactly 64 cycles later; every entry reads 2'b01.
REQ-035 Agreement: global=1, local=1, any ctr -> pred_taken_o=1; global=0, local=0 -> 0.
REQ-036 Saturation: 3 updates same PC, global-correct-only -> ctr 1->2->3->3; predict global=1, local=0 -> pred_taken_o=1, pred_sel_global_o=1; 4 local-correct-only updates -> ctr 0, pred_taken_o=0.
REQ-037 Collision: predict and update same idx same cycle (ctr=1, global-correct-only) -> pred_ctr_o=1; next-cycle predict -> pred_ctr_o=2.
REQ-038 GHR: USE_GHR=1, updates taken 1,0,1 from reset -> ghr_o=6'b000101; a prediction at pc=0 then indexes entry 5.
REQ-039 Reset mid-stream: reset during READY with pred_v_i=1 -> pred_v_o=0 next cycle, ready_o=0, requests and updates dropped until re-initialised.
